// File: rtl/sn_noise_lfsr_pkg.sv
// Shared types and defaults for the SN76489 noise channel.
// Optional shift counter is enabled by defining SN_NOISE_SHIFT_CNT_EN.
package sn76489_pkg;

   typedef enum logic [1:0] {
      NF_DIV1  = 2'd0,
      NF_DIV2  = 2'd1,
      NF_DIV4  = 2'd2,
      NF_TONE3 = 2'd3
   } noise_rate_e;

   typedef enum logic {
      FB_PERIODIC = 1'b0,
      FB_WHITE    = 1'b1
   } noise_fb_e;

   // Field order matches the NOISE_CTRL bit layout: [2]=FB, [1:0]=NF.
   typedef struct packed {
      noise_fb_e   fb;
      noise_rate_e nf;
   } noise_ctrl_t;

   localparam int unsigned SN_NOISE_WIDTH = 16;
   localparam logic [15:0] SN_NOISE_SEED  = 16'h8000;

endpackage

// File: rtl/sn_noise_lfsr_if.sv
// Control/status bundle between the noise register write path, the LFSR and the attenuator.
// SHIFT_CNT exists only when SN_NOISE_SHIFT_CNT_EN is defined.
interface sn_noise_lfsr_if #(
   parameter int unsigned WIDTH = 16
);
   logic             CLK_EN;
   logic             NOISE_WE;
   logic [2:0]       NOISE_CTRL;
   logic             TONE3_EDGE;
   logic             BIT_OUT;
   logic             SHIFT_STROBE;
   logic [WIDTH-1:0] LFSR_STATE;
`ifdef SN_NOISE_SHIFT_CNT_EN
   logic [15:0]      SHIFT_CNT;
`endif

   modport master (
      output CLK_EN, NOISE_WE, NOISE_CTRL, TONE3_EDGE,
`ifdef SN_NOISE_SHIFT_CNT_EN
      input  SHIFT_CNT,
`endif
      input  BIT_OUT, SHIFT_STROBE, LFSR_STATE
   );

   modport slave (
      input  CLK_EN, NOISE_WE, NOISE_CTRL, TONE3_EDGE,
`ifdef SN_NOISE_SHIFT_CNT_EN
      output SHIFT_CNT,
`endif
      output BIT_OUT, SHIFT_STROBE, LFSR_STATE
   );

endinterface

// File: rtl/sn_noise_lfsr_rate_div.sv
// Noise shift-rate divider: counts chip-rate ticks per NF, or passes tone-3 edges through.
// Used by sn_noise_lfsr (optional SN_NOISE_SHIFT_CNT_EN lives in the top only).
module sn_noise_rate_div
   import sn76489_pkg::*;
#(
   parameter int unsigned DIV_BASE = 32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CLK_EN,
   input  logic        TONE3_EDGE,
   input  noise_rate_e nf,
   input  logic        clr,
   output logic        shift_req
);

   localparam int unsigned DW = $clog2(DIV_BASE * 4);

   logic [DW-1:0] div_q, div_d;
   logic [DW-1:0] term;

   if (DIV_BASE < 1) begin : g_chk_div
      $error("sn_noise_rate_div: DIV_BASE must be at least 1");
   end

   always_comb begin
      case (nf)
         NF_DIV1: term = DW'(DIV_BASE - 1);
         NF_DIV2: term = DW'(DIV_BASE * 2 - 1);
         default: term = DW'(DIV_BASE * 4 - 1);
      endcase
   end

   always_comb begin
      div_d     = div_q;
      shift_req = 1'b0;
      if (nf == NF_TONE3) begin
         div_d     = '0;
         shift_req = TONE3_EDGE;
      end else if (CLK_EN) begin
         if (div_q == term) begin
            div_d     = '0;
            shift_req = 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
      // A control write restarts the count; the request is discarded by the caller.
      if (clr) begin
         div_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/sn_noise_lfsr.sv
// SN76489 noise LFSR: control register, right-shifting LFSR, write priority and shift strobe.
// Define SN_NOISE_SHIFT_CNT_EN to add the 16-bit performed-shift counter (SHIFT_CNT).
module sn_noise_lfsr
   import sn76489_pkg::*;
#(
   parameter int unsigned      WIDTH    = SN_NOISE_WIDTH,
   parameter int unsigned      TAP_A    = 0,
   parameter int unsigned      TAP_B    = 3,
   parameter logic [WIDTH-1:0] SEED     = WIDTH'(SN_NOISE_SEED),
   parameter int unsigned      DIV_BASE = 32
) (
   input  logic          CLK,
   input  logic          RST,
   sn_noise_lfsr_if.slave bus
);

   if (WIDTH < 4) begin : g_chk_width
      $error("sn_noise_lfsr: WIDTH must be at least 4");
   end
   if (TAP_A >= WIDTH || TAP_B >= WIDTH) begin : g_chk_tap_range
      $error("sn_noise_lfsr: feedback taps must be below WIDTH");
   end
   if (TAP_A == TAP_B) begin : g_chk_tap_dup
      $error("sn_noise_lfsr: TAP_A and TAP_B must differ");
   end
   if (SEED == '0) begin : g_chk_seed
      $error("sn_noise_lfsr: SEED must be nonzero");
   end

   noise_ctrl_t      ctrl_q, ctrl_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic             strobe_q, strobe_d;
   logic             shift_req;
   logic             fb;

   sn_noise_rate_div #(
      .DIV_BASE (DIV_BASE)
   ) u_rate_div (
      .CLK        (CLK),
      .RST        (RST),
      .CLK_EN     (bus.CLK_EN),
      .TONE3_EDGE (bus.TONE3_EDGE),
      .nf         (ctrl_q.nf),
      .clr        (bus.NOISE_WE),
      .shift_req  (shift_req)
   );

   assign fb = (ctrl_q.fb == FB_WHITE) ? (lfsr_q[TAP_A] ^ lfsr_q[TAP_B]) : lfsr_q[0];

   always_comb begin
      ctrl_d   = ctrl_q;
      lfsr_d   = lfsr_q;
      strobe_d = 1'b0;
      if (bus.NOISE_WE) begin
         ctrl_d = noise_ctrl_t'(bus.NOISE_CTRL);
         lfsr_d = SEED;
      end else if (shift_req) begin
         lfsr_d   = {fb, lfsr_q[WIDTH-1:1]};
         strobe_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ctrl_q   <= noise_ctrl_t'(3'b000);
         lfsr_q   <= SEED;
         strobe_q <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         lfsr_q   <= lfsr_d;
         strobe_q <= strobe_d;
      end
   end

   assign bus.BIT_OUT      = lfsr_q[0];
   assign bus.SHIFT_STROBE = strobe_q;
   assign bus.LFSR_STATE   = lfsr_q;

`ifdef SN_NOISE_SHIFT_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (bus.NOISE_WE) begin
         cnt_d = '0;
      end else if (shift_req) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.SHIFT_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_sn_noise_lfsr.sv
// Directed bench for sn_noise_lfsr; the SHIFT_CNT section runs only with SN_NOISE_SHIFT_CNT_EN.
module tb_sn_noise_lfsr;
   import sn76489_pkg::*;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   int   nstb;

   sn_noise_lfsr_if #(.WIDTH(16)) bus ();

   sn_noise_lfsr #(
      .WIDTH    (16),
      .TAP_A    (0),
      .TAP_B    (3),
      .SEED     (16'h8000),
      .DIV_BASE (32)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n chip-rate ticks, counting the strobes seen after each edge
   task automatic en_pulses(input int n, output int strobes);
      strobes = 0;
      for (int i = 0; i < n; i++) begin
         bus.CLK_EN = 1'b1;
         tick();
         if (bus.SHIFT_STROBE === 1'b1) strobes++;
      end
      bus.CLK_EN = 1'b0;
   endtask

   task automatic tone_pulses(input int n, output int strobes);
      strobes = 0;
      for (int i = 0; i < n; i++) begin
         bus.TONE3_EDGE = 1'b1;
         tick();
         if (bus.SHIFT_STROBE === 1'b1) strobes++;
      end
      bus.TONE3_EDGE = 1'b0;
   endtask

   task automatic write_ctrl(input logic [2:0] v);
      bus.NOISE_WE   = 1'b1;
      bus.NOISE_CTRL = v;
      tick();
      bus.NOISE_WE   = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      bus.CLK_EN     = 1'b0;
      bus.NOISE_WE   = 1'b0;
      bus.NOISE_CTRL = 3'b000;
      bus.TONE3_EDGE = 1'b0;
      tick();
      tick();
      chk("rst_state", 32'(bus.LFSR_STATE), 32'h8000);
      chk("rst_bit", 32'(bus.BIT_OUT), 32'd0);
      chk("rst_strobe", 32'(bus.SHIFT_STROBE), 32'd0);
`ifdef SN_NOISE_SHIFT_CNT_EN
      chk("rst_cnt", 32'(bus.SHIFT_CNT), 32'd0);
`endif
      rst = 1'b0;
      tick();

      // Periodic, NF=0
      en_pulses(31, nstb);
      chk("per_31_nostrobe", 32'(nstb), 32'd0);
      en_pulses(1, nstb);
      chk("per_32_strobe", 32'(nstb), 32'd1);
      chk("per_1shift", 32'(bus.LFSR_STATE), 32'h4000);
      tick();
      chk("per_strobe_1cyc", 32'(bus.SHIFT_STROBE), 32'd0);
      en_pulses(32 * 14, nstb);
      chk("per_14_strobes", 32'(nstb), 32'd14);
      chk("per_15shift", 32'(bus.LFSR_STATE), 32'h0001);
      chk("per_15bit", 32'(bus.BIT_OUT), 32'd1);
      en_pulses(32, nstb);
      chk("per_16shift", 32'(bus.LFSR_STATE), 32'h8000);

      // Async reset mid-count, right after a shift
      en_pulses(32 + 10, nstb);
      en_pulses(22, nstb);
      chk("pre_rst_strobe", 32'(bus.SHIFT_STROBE), 32'd1);
      chk("pre_rst_state", 32'(bus.LFSR_STATE), 32'h2000);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 32'(bus.LFSR_STATE), 32'h8000);
      chk("arst_bit", 32'(bus.BIT_OUT), 32'd0);
      chk("arst_strobe", 32'(bus.SHIFT_STROBE), 32'd0);
      tick();
      rst = 1'b0;
      en_pulses(10, nstb);
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      en_pulses(31, nstb);
      chk("arst_div_clr", 32'(nstb), 32'd0);
      en_pulses(1, nstb);
      chk("arst_div_term", 32'(nstb), 32'd1);

      // White, NF=0
      write_ctrl(3'b100);
      chk("wr_white_seed", 32'(bus.LFSR_STATE), 32'h8000);
      en_pulses(32 * 12, nstb);
      chk("white_12", 32'(bus.LFSR_STATE), 32'h0008);
      en_pulses(32, nstb);
      chk("white_13", 32'(bus.LFSR_STATE), 32'h8004);
      en_pulses(32, nstb);
      chk("white_14", 32'(bus.LFSR_STATE), 32'h4002);

      // Periodic, NF=2
      write_ctrl(3'b010);
      en_pulses(127, nstb);
      chk("nf2_127", 32'(nstb), 32'd0);
      en_pulses(1, nstb);
      chk("nf2_128", 32'(nstb), 32'd1);
      chk("nf2_state", 32'(bus.LFSR_STATE), 32'h4000);
      en_pulses(128, nstb);
      chk("nf2_second", 32'(nstb), 32'd1);
      chk("nf2_state2", 32'(bus.LFSR_STATE), 32'h2000);

      // Tone-3 clocked, NF=3
      write_ctrl(3'b011);
      en_pulses(200, nstb);
      chk("nf3_clken_only", 32'(nstb), 32'd0);
      chk("nf3_clken_state", 32'(bus.LFSR_STATE), 32'h8000);
      tone_pulses(5, nstb);
      chk("nf3_tone_strobes", 32'(nstb), 32'd5);
      chk("nf3_tone_state", 32'(bus.LFSR_STATE), 32'h0400);
      bus.NOISE_WE   = 1'b1;
      bus.TONE3_EDGE = 1'b1;
      tick();
      bus.NOISE_WE   = 1'b0;
      bus.TONE3_EDGE = 1'b0;
      chk("nf3_we_coll_state", 32'(bus.LFSR_STATE), 32'h8000);
      chk("nf3_we_coll_strobe", 32'(bus.SHIFT_STROBE), 32'd0);

      // WE colliding with a divider terminal count, then a mid-count write
      write_ctrl(3'b000);
      en_pulses(31, nstb);
      bus.CLK_EN     = 1'b1;
      bus.NOISE_WE   = 1'b1;
      bus.NOISE_CTRL = 3'b000;
      tick();
      bus.CLK_EN   = 1'b0;
      bus.NOISE_WE = 1'b0;
      chk("we_coll_state", 32'(bus.LFSR_STATE), 32'h8000);
      chk("we_coll_strobe", 32'(bus.SHIFT_STROBE), 32'd0);
      en_pulses(20, nstb);
      write_ctrl(3'b000);
      en_pulses(31, nstb);
      chk("midwr_31", 32'(nstb), 32'd0);
      en_pulses(1, nstb);
      chk("midwr_32", 32'(nstb), 32'd1);
      chk("midwr_state", 32'(bus.LFSR_STATE), 32'h4000);

`ifdef SN_NOISE_SHIFT_CNT_EN
      write_ctrl(3'b011);
      chk("cnt_we_clear0", 32'(bus.SHIFT_CNT), 32'd0);
      tone_pulses(70000, nstb);
      chk("cnt_strobes", 32'(nstb), 32'd70000);
      chk("cnt_wrap", 32'(bus.SHIFT_CNT), 32'd4464);
      write_ctrl(3'b000);
      chk("cnt_we_clear", 32'(bus.SHIFT_CNT), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
